// File: rtl/seq_multiplier.sv
// Iterative 32x32 shift-add multiplier: signed or unsigned operands, returns the
// selected 32-bit half of the 64-bit product with a one-cycle ready strobe.
module seq_multiplier (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] A_i,
  input  logic [31:0] B_i,
  input  logic        enable_i,
  input  logic        up_or_low_i,
  input  logic        sign_i,
  output logic [31:0] Product,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [63:0] acc_r;
  logic [31:0] mcand_r;
  logic [31:0] mplier_r;
  logic        neg_r;
  logic        up_r;
  logic [5:0]  cnt_r;

  logic        start_s;
  logic        iter_s;
  logic        finish_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [32:0] sum_s;
  logic [63:0] result_s;

  // 0x80000000 maps to itself, which is the correct unsigned magnitude 2^31
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
    if (sgn && v[31]) begin
      return ~v + 32'd1;
    end else begin
      return v;
    end
  endfunction

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; cnt_r reaching 32 marks the finalize cycle
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable_i) state_s = BUSY;
        else          state_s = IDLE;
      end
      BUSY: begin
        if (cnt_r == 6'd32) state_s = DONE;
        else                state_s = BUSY;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Control strobes derived from the current state
  always_comb begin
    start_s  = 1'b0;
    iter_s   = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      IDLE: start_s = enable_i;
      BUSY: begin
        if (cnt_r == 6'd32) finish_s = 1'b1;
        else                iter_s   = 1'b1;
      end
      DONE:    start_s = 1'b0;
      default: start_s = 1'b0;
    endcase
  end

  // Operand magnitudes, one shift-add step and the sign-corrected result
  always_comb begin
    a_mag_s  = magnitude(A_i, sign_i);
    b_mag_s  = magnitude(B_i, sign_i);
    sum_s    = {1'b0, acc_r[63:32]} + (mplier_r[0] ? {1'b0, mcand_r} : 33'd0);
    if (neg_r) begin
      result_s = ~acc_r + 64'd1;
    end else begin
      result_s = acc_r;
    end
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_r    <= 64'd0;
      mcand_r  <= 32'd0;
      mplier_r <= 32'd0;
      neg_r    <= 1'b0;
      up_r     <= 1'b0;
      cnt_r    <= 6'd0;
    end else if (start_s) begin
      acc_r    <= 64'd0;
      mcand_r  <= a_mag_s;
      mplier_r <= b_mag_s;
      neg_r    <= sign_i & (A_i[31] ^ B_i[31]);
      up_r     <= up_or_low_i;
      cnt_r    <= 6'd0;
    end else if (iter_s) begin
      acc_r    <= {sum_s, acc_r[31:1]};
      mplier_r <= {1'b0, mplier_r[31:1]};
      cnt_r    <= cnt_r + 6'd1;
    end
  end

  // Registered outputs: Product only changes on completion
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      Product <= 32'd0;
      ready_o <= 1'b0;
    end else begin
      ready_o <= finish_s;
      if (finish_s) begin
        Product <= up_r ? result_s[63:32] : result_s[31:0];
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: hand-computed products, latency, strobe
// width, output hold, ignored mid-operation starts and mid-operation reset.
module tb_seq_multiplier;

  logic        clk;
  logic        resetn;
  logic [31:0] A_i;
  logic [31:0] B_i;
  logic        enable_i;
  logic        up_or_low_i;
  logic        sign_i;
  logic [31:0] Product;
  logic        ready_o;

  int n_vec;
  int n_bad;
  logic [31:0] last_exp;

  seq_multiplier dut (
    .clk         (clk),
    .resetn      (resetn),
    .A_i         (A_i),
    .B_i         (B_i),
    .enable_i    (enable_i),
    .up_or_low_i (up_or_low_i),
    .sign_i      (sign_i),
    .Product     (Product),
    .ready_o     (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One start pulse; optionally pokes a different request mid-operation
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic up, input logic [31:0] exp,
                        input bit poke);
    int cyc;
    int hold_err;
    bit done;
    @(negedge clk);
    A_i = a; B_i = b; sign_i = sgn; up_or_low_i = up; enable_i = 1'b1;
    @(posedge clk); #1;
    enable_i = 1'b0;
    A_i = 32'hDEAD_BEEF; B_i = 32'h1234_5678; sign_i = ~sgn; up_or_low_i = ~up;
    check_val({tag, "_rdy_after_start"}, {31'd0, ready_o}, 32'd0);
    cyc = 0; hold_err = 0; done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      if (poke && cyc == 5) begin
        A_i = 32'd5; B_i = 32'd7; sign_i = 1'b0; up_or_low_i = 1'b0; enable_i = 1'b1;
      end else begin
        enable_i = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (ready_o) done = 1'b1;
      else if (Product !== last_exp) hold_err++;
    end
    enable_i = 1'b0;
    check_val({tag, "_latency"}, cyc, 32'd33);
    check_val({tag, "_product"}, Product, exp);
    check_val({tag, "_hold_busy"}, hold_err, 32'd0);
    @(posedge clk); #1;
    check_val({tag, "_rdy_one_cycle"}, {31'd0, ready_o}, 32'd0);
    check_val({tag, "_prod_held"}, Product, exp);
    last_exp = exp;
  endtask

  initial begin
    int strobes;
    n_vec = 0; n_bad = 0; last_exp = 32'd0;
    resetn = 1'b0; enable_i = 1'b0; A_i = 32'd0; B_i = 32'd0;
    up_or_low_i = 1'b0; sign_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_product", Product, 32'd0);
    check_val("reset_ready", {31'd0, ready_o}, 32'd0);
    @(negedge clk); resetn = 1'b1;

    run_op("u_117x23_lo",    32'd117,        32'd23,         1'b0, 1'b0, 32'h0000_0A83, 1'b0);
    run_op("s_117xm23_lo",   32'd117,        32'hFFFF_FFE9,  1'b1, 1'b0, 32'hFFFF_F57D, 1'b0);
    run_op("s_m117xm23_lo",  32'hFFFF_FF8B,  32'hFFFF_FFE9,  1'b1, 1'b0, 32'h0000_0A83, 1'b0);
    run_op("u_64k_sq_lo",    32'h0001_0000,  32'h0001_0000,  1'b0, 1'b0, 32'h0000_0000, 1'b0);
    run_op("u_64k_sq_hi",    32'h0001_0000,  32'h0001_0000,  1'b0, 1'b1, 32'h0000_0001, 1'b0);
    run_op("u_ffff_sq_hi",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    run_op("u_ffff_sq_lo",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b0, 32'h0000_0001, 1'b0);
    run_op("s_m1x1_hi",      32'hFFFF_FFFF,  32'd1,          1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    run_op("s_min_sq_hi",    32'h8000_0000,  32'h8000_0000,  1'b1, 1'b1, 32'h4000_0000, 1'b0);
    run_op("s_min_sq_lo",    32'h8000_0000,  32'h8000_0000,  1'b1, 1'b0, 32'h0000_0000, 1'b0);
    run_op("poke_in_busy",   32'd117,        32'd23,         1'b0, 1'b0, 32'h0000_0A83, 1'b1);

    // The poked request must not have been queued
    strobes = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) strobes++;
    end
    check_val("no_queued_req", strobes, 32'd0);

    // Reset mid-operation: immediate clear, no late strobe
    @(negedge clk);
    A_i = 32'd1000; B_i = 32'd1000; sign_i = 1'b0; up_or_low_i = 1'b0; enable_i = 1'b1;
    @(posedge clk); #1;
    enable_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_val("midrst_product", Product, 32'd0);
    check_val("midrst_ready", {31'd0, ready_o}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    last_exp = 32'd0;
    strobes = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) strobes++;
    end
    check_val("midrst_no_strobe", strobes, 32'd0);
    run_op("after_reset",    32'd117,        32'hFFFF_FFE9,  1'b1, 1'b0, 32'hFFFF_F57D, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
